// File: rtl/updown_dir_decoder.sv
// Observes an up/down counter's output bus and reconstructs its behaviour:
// direction, wrap events, reversals, run length and illegal steps. All outputs are registered.
module updown_dir_decoder #(
   parameter int unsigned N = 3,
   parameter int unsigned L = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         clr,
   input  logic [N-1:0] counter,
   output logic         dir,
   output logic         dir_valid,
   output logic         wrap,
   output logic         dir_change,
   output logic         err,
   output logic         err_sticky,
   output logic [L-1:0] run_len
);

   typedef enum logic [1:0] {StIdle, StAcq, StUp, StDown} state_e;
   typedef enum logic [1:0] {StepHold, StepUp, StepDn, StepBad} step_e;

   localparam logic [N-1:0] MaxVal = '1;
   localparam logic [N-1:0] OneVal = N'(1);
   localparam logic [L-1:0] RunMax = '1;

   state_e       state_q, state_d;
   logic [N-1:0] prev_q, prev_d;
   logic [L-1:0] run_len_q, run_len_d;
   logic         dir_q, dir_d;
   logic         wrap_q, wrap_d;
   logic         dir_change_q, dir_change_d;
   logic         err_q, err_d;
   logic         err_sticky_q, err_sticky_d;

   logic [N-1:0] delta;
   step_e        step;
   logic [L-1:0] run_len_inc;
   logic         step_wrap;

   always_comb begin
      delta = counter - prev_q;
      if (delta == '0) begin
         step = StepHold;
      end else if (delta == OneVal) begin
         step = StepUp;
      end else if (delta == MaxVal) begin
         step = StepDn;
      end else begin
         step = StepBad;
      end
   end

   // A legal step wraps when it crosses the max/0 boundary, whichever direction it goes.
   assign step_wrap   = ((step == StepUp) && (prev_q == MaxVal)) ||
                        ((step == StepDn) && (prev_q == '0));
   assign run_len_inc = (run_len_q == RunMax) ? RunMax : run_len_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      prev_d       = prev_q;
      run_len_d    = run_len_q;
      dir_d        = dir_q;
      wrap_d       = 1'b0;
      dir_change_d = 1'b0;
      err_d        = 1'b0;
      err_sticky_d = err_sticky_q;

      if (en) begin
         prev_d = counter;
         unique case (state_q)
            StIdle: state_d = StAcq;
            StAcq: begin
               if (step == StepUp) begin
                  state_d   = StUp;
                  dir_d     = 1'b1;
                  run_len_d = L'(1);
               end else if (step == StepDn) begin
                  state_d   = StDown;
                  dir_d     = 1'b0;
                  run_len_d = L'(1);
               end else if (step == StepBad) begin
                  err_d = 1'b1;
               end
            end
            StUp, StDown: begin
               if (step == StepBad) begin
                  state_d   = StAcq;
                  err_d     = 1'b1;
                  run_len_d = '0;
               end else if (step != StepHold) begin
                  wrap_d = step_wrap;
                  if ((step == StepUp) == (state_q == StUp)) begin
                     run_len_d = run_len_inc;
                  end else begin
                     state_d      = (step == StepUp) ? StUp : StDown;
                     dir_d        = (step == StepUp);
                     dir_change_d = 1'b1;
                     run_len_d    = L'(1);
                  end
               end
            end
            default: state_d = StIdle;
         endcase
      end

      // Set beats clear when both happen in one cycle.
      if (clr) begin
         err_sticky_d = 1'b0;
      end
      if (err_d) begin
         err_sticky_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         prev_q       <= '0;
         run_len_q    <= '0;
         dir_q        <= 1'b1;
         wrap_q       <= 1'b0;
         dir_change_q <= 1'b0;
         err_q        <= 1'b0;
         err_sticky_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_q       <= prev_d;
         run_len_q    <= run_len_d;
         dir_q        <= dir_d;
         wrap_q       <= wrap_d;
         dir_change_q <= dir_change_d;
         err_q        <= err_d;
         err_sticky_q <= err_sticky_d;
      end
   end

   assign dir        = dir_q;
   assign dir_valid  = (state_q == StUp) || (state_q == StDown);
   assign wrap       = wrap_q;
   assign dir_change = dir_change_q;
   assign err        = err_q;
   assign err_sticky = err_sticky_q;
   assign run_len    = run_len_q;

endmodule

// File: tb/tb_updown_dir_decoder.sv
// Scoreboard bench: stimulus pushes model predictions into a queue, a monitor pops and compares
// them against the registered outputs after every rising edge.
module tb_updown_dir_decoder;

   localparam int N = 3;
   localparam int L = 8;
   localparam int M = 1 << N;
   localparam int RunMax = (1 << L) - 1;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b0;
   logic         clr = 1'b0;
   logic [N-1:0] counter = '0;
   logic         dir, dir_valid, wrap, dir_change, err, err_sticky;
   logic [L-1:0] run_len;

   updown_dir_decoder #(.N(N), .L(L)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .clr        (clr),
      .counter    (counter),
      .dir        (dir),
      .dir_valid  (dir_valid),
      .wrap       (wrap),
      .dir_change (dir_change),
      .err        (err),
      .err_sticky (err_sticky),
      .run_len    (run_len)
   );

   always #5 clk = ~clk;

   // Packed as {dir, dir_valid, wrap, dir_change, err, err_sticky, run_len}.
   typedef logic [L+5:0] obs_t;
   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Reference model: mode 0=idle, 1=acquiring, 2=tracking up, 3=tracking down.
   int m_mode = 0;
   int m_prev = 0;
   int m_run = 0;
   bit m_dir = 1'b1;
   bit m_sticky = 1'b0;

   function automatic obs_t observe();
      return {dir, dir_valid, wrap, dir_change, err, err_sticky, run_len};
   endfunction

   function automatic obs_t reset_obs();
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, L'(0)};
   endfunction

   task automatic drive(input bit e, input bit c, input int cnt, input bit r);
      bit w, dc, er;
      int d;
      bit up, dn, bad;
      @(negedge clk);
      reset   = r;
      en      = e;
      clr     = c;
      counter = cnt[N-1:0];
      w = 0; dc = 0; er = 0;
      if (r) begin
         m_mode = 0; m_prev = 0; m_run = 0; m_dir = 1; m_sticky = 0;
      end else begin
         if (e) begin
            d   = ((cnt - m_prev) % M + M) % M;
            up  = (d == 1);
            dn  = (d == M - 1);
            bad = !up && !dn && (d != 0);
            if (m_mode == 0) begin
               m_mode = 1;
            end else if (m_mode == 1) begin
               if (up || dn) begin
                  m_mode = up ? 2 : 3; m_run = 1; m_dir = up;
               end else if (bad) begin
                  er = 1;
               end
            end else if (bad) begin
               m_mode = 1; m_run = 0; er = 1;
            end else if (up || dn) begin
               w = up ? (m_prev == M - 1) : (m_prev == 0);
               if (up == (m_mode == 2)) begin
                  m_run = (m_run < RunMax) ? m_run + 1 : RunMax;
               end else begin
                  m_mode = up ? 2 : 3; m_dir = up; m_run = 1; dc = 1;
               end
            end
            m_prev = cnt % M;
         end
         if (c) m_sticky = 0;
         if (er) m_sticky = 1;
      end
      exp_q.push_back({m_dir, (m_mode >= 2), w, dc, er, m_sticky, L'(m_run)});
   endtask

   task automatic check_now(input string name, input obs_t want);
      obs_t got;
      got = observe();
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (dir,vld,wrap,chg,err,stk,run)", name, got, want);
      end
   endtask

   task automatic run_seq(input int vals[$]);
      drive(0, 0, 0, 1);
      foreach (vals[i]) drive(1, 0, vals[i], 0);
   endtask

   initial begin
      obs_t want;
      obs_t got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = observe();
            n_vec++;
            if (got !== want) begin
               n_bad++;
               $display("FAIL cycle@%0t: got %h want %h (dir,vld,wrap,chg,err,stk,run)",
                        $time, got, want);
            end
         end
      end
   end

   initial begin
      int cur;
      int r;
      drive(0, 0, 0, 1);
      drive(0, 0, 0, 1);
      run_seq('{0, 1, 2, 3, 4, 5, 6, 7, 0, 1});
      run_seq('{3, 4, 5, 4, 3});
      run_seq('{1, 0, 7, 6});
      run_seq('{2, 3, 6, 7});
      drive(0, 1, 7, 0);
      drive(1, 1, 5, 0);
      run_seq('{4, 5, 5, 5, 6});
      drive(0, 0, 1, 0);
      drive(0, 0, 3, 0);

      // Asynchronous reset between edges while tracking up with run_len=5.
      run_seq('{0, 1, 2, 3, 4, 5});
      drive(0, 0, 5, 1);
      #1 check_now("async_reset", reset_obs());
      drive(1, 0, 2, 0);
      drive(1, 0, 3, 0);

      // Long up run drives run_len into saturation across several wraps.
      drive(0, 0, 0, 1);
      for (int i = 0; i < 300; i++) drive(1, 0, i % M, 0);
      drive(1, 0, 7, 0);

      cur = 0;
      for (int i = 0; i < 2000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 40) cur = (cur + 1) % M;
         else if (r < 62) cur = (cur + M - 1) % M;
         else if (r < 75) cur = cur;
         else if (r < 82) cur = $urandom_range(0, M - 1);
         else cur = (cur + 1) % M;
         drive(($urandom % 8) != 0, ($urandom % 16) == 0, cur, ($urandom % 250) == 0);
      end

      @(posedge clk);
      #3;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/updown_dir_decoder.md
# updown_dir_decoder

Receive-side companion to the N-bit up/down counter: samples the counter's output bus and reconstructs what the counter is doing. Outputs are counting direction, wrap events, direction reversals, current run length and illegal-step errors. Sits next to the counter in the same clock domain and gives testbenches and system logic a registered view of counter behaviour, without access to the counter's mode input.

## Interface
- N, 3, counter width in bits; N >= 2 required (for N=1, +1 and -1 steps are indistinguishable).
- L, 8, width of the run-length output.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset; one clock, no other clock domains.
- en  input  1  sample strobe; `counter` is examined only on cycles with en=1.
- clr  input  1  synchronous clear of `err_sticky` only.
- counter  input  N  counter value under observation.
- dir  output  1  1 = counting up, 0 = counting down; meaningful only when dir_valid=1.
- dir_valid  output  1  1 while in TRACK_UP or TRACK_DOWN.
- wrap  output  1  one-cycle pulse on a legal wrap step (max->0 going up, 0->max going down).
- dir_change  output  1  one-cycle pulse on a legal reversal between the tracking states.
- err  output  1  one-cycle pulse on an illegal step.
- err_sticky  output  1  set by err, held until clr or reset.
- run_len  output  L  consecutive legal steps in the current direction; saturates at 2^L-1.

## Operation
- Internal registers:
  - prev[N-1:0]: last accepted sample.
  - state: IDLE, ACQ, TRACK_UP, TRACK_DOWN.
- On every en=1 cycle outside IDLE:
  - delta = (counter - prev) mod 2^N.
  - Classification: STEP_UP if delta==1; STEP_DN if delta==2^N-1; HOLD if delta==0; otherwise BAD.
- prev is loaded with `counter` on every en=1 cycle, in every state, for every classification.
- IDLE: capture prev; go to ACQ. No pulses.
- ACQ:
  - STEP_UP -> TRACK_UP, run_len=1.
  - STEP_DN -> TRACK_DOWN, run_len=1.
  - HOLD -> stay.
  - BAD -> err pulse, stay.
- TRACK_UP:
  - STEP_UP -> stay, run_len+1 (saturating); wrap pulse if prev==2^N-1.
  - STEP_DN -> TRACK_DOWN, dir_change pulse, run_len=1; wrap pulse if prev==0.
  - HOLD -> stay, nothing changes.
  - BAD -> ACQ, err pulse, run_len=0.
- TRACK_DOWN: mirror of TRACK_UP.
  - STEP_DN continues, with wrap if prev==0.
  - STEP_UP reverses, with wrap if prev==2^N-1.
- dir = 1 in TRACK_UP, 0 in TRACK_DOWN. dir holds its last value in ACQ and IDLE; dir_valid=0 there.
- en=0: no state, prev or run_len change; all pulses 0.
- clr and err pulse in the same cycle: set wins, err_sticky=1.
- err_sticky is never cleared by state transitions.

## Timing
- All outputs are registered and update on the clk edge that samples en=1. Latency is one cycle from sample to output.
- Pulses (wrap, dir_change, err) last exactly one cycle. Back-to-back en=1 cycles may pulse on consecutive cycles.
- Reset, asserted at any time including mid-run:
  - state=IDLE, prev=0, dir=1, dir_valid=0, run_len=0.
  - wrap=0, dir_change=0, err=0, err_sticky=0.
- After reset deasserts, the first en=1 sample is only captured. Earliest dir_valid=1 is on the edge of the second en=1 sample.
- run_len saturates at 2^L-1 with no wrap. wrap and dir_change pulses are unaffected by saturation.

## Test plan
- Up count, N=3: reset 2 cycles; en=1; counter 0,1,2,...,7,0,1 -> dir_valid=1 from the 2nd sample; dir=1; run_len 1..9; single wrap pulse on the 7->0 sample; no err.
- Down count with reversal: counter 3,4,5,4,3 -> TRACK_UP (run_len 1,2), then dir_change pulse on 5->4, dir=0, run_len=1, then run_len=2 on 3.
- Down wrap: counter 1,0,7,6 -> TRACK_DOWN; wrap pulse on 0->7; run_len=3 at 6; dir_change never pulses.
- Illegal step and sticky: counter 2,3,6 -> err pulse on 6, state ACQ, dir_valid=0, run_len=0, err_sticky=1. Then 7 -> TRACK_UP, run_len=1. clr=1 -> err_sticky=0 next edge.
- Hold and en gating: counter 4,5,5,5,6 with en=1 -> run_len stays 1 during holds, then 2. en=0 while counter jumps to 1 -> no err, no change.
- Reset mid-operation: in TRACK_UP with run_len=5, assert reset between edges -> outputs immediately at reset values. After release, samples 2,3 -> err stays 0 and dir_valid=1 on the second sample.
